// File: rtl/srfpu_round_pkg.sv
// Shared types, constants and the round-robin pick helper for the SRFPU rounding units.
package srfpu_round_pkg;

  localparam int          LFSR_WIDTH = 16;
  // Taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          RR_MAX     = 8;

  typedef enum logic {
    RM_NEAREST = 1'b0,
    RM_STOCH   = 1'b1
  } round_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_e;

  // First valid index at or after ptr, wrapping at num_req.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         num_req);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = (int'(ptr) + i) % num_req;
      if ((i < num_req) && !found && valid[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/round.sv
// Round-half-up / stochastic mantissa rounder; result keeps the carry-out bit.
module round
  import srfpu_round_pkg::*;
#(
  parameter int MANT_WIDTH     = 23,
  parameter int NUM_ROUND_BITS = 8
) (
  input  logic [MANT_WIDTH+NUM_ROUND_BITS-1:0] mant_in,
  input  logic [NUM_ROUND_BITS-1:0]            rand_in,
  input  logic                                 mode,
  output logic [MANT_WIDTH:0]                  rounded
);

  localparam int SUM_W = MANT_WIDTH + NUM_ROUND_BITS + 1;

  logic [SUM_W-1:0] addend;
  logic [SUM_W-1:0] sum;

  always_comb begin
    addend = {SUM_W{1'b0}};
    case (mode)
      RM_STOCH:   addend = SUM_W'(rand_in);
      RM_NEAREST: addend = SUM_W'(1) << (NUM_ROUND_BITS - 1);
      default:    addend = {SUM_W{1'b0}};
    endcase
    sum = {1'b0, mant_in} + addend;
  end

  assign rounded = sum[SUM_W-1 -: MANT_WIDTH+1];

endmodule

// File: rtl/sr_lfsr.sv
// 16-bit Fibonacci LFSR that steps only when told to; shared by the SR units.
module sr_lfsr
  import srfpu_round_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = LFSR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [OUT_W-1:0] state
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [LFSR_WIDTH-1:0] state_d;
  logic [LFSR_WIDTH-1:0] state_q;

  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = {state_q[LFSR_WIDTH-2:0], ^(state_q & LFSR_TAPS)};
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q[OUT_W-1:0];

endmodule

// File: rtl/round_sched.sv
// Round-robin scheduler sharing one rounding datapath between NUM_REQ requesters.
// Optional counters are built when ROUND_SCHED_STATS_EN is defined.
module round_sched
  import srfpu_round_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter int          MANT_WIDTH     = 23,
  parameter int          NUM_ROUND_BITS = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         ID_W           = $clog2(NUM_REQ),
  localparam int         IN_W           = MANT_WIDTH + NUM_ROUND_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_mant,
  input  logic [NUM_REQ-1:0]      req_stochastic,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic [MANT_WIDTH:0]     out_rounded,
  output logic                    out_overflow
`ifdef ROUND_SCHED_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [31:0]             stat_sr_cnt,
  output logic [31:0]             stat_rn_cnt,
  output logic [31:0]             stat_ovf_cnt
`endif
);

  sched_state_e              state_d, state_q;
  logic [ID_W-1:0]           ptr_d, ptr_q;
  logic [ID_W-1:0]           out_id_d, out_id_q;
  logic [MANT_WIDTH:0]       out_rounded_d, out_rounded_q;

  logic                      can_accept;
  logic                      any_valid;
  logic                      accept;
  logic [ID_W-1:0]           grant;
  logic [ID_W-1:0]           grant_next;
  logic [IN_W-1:0]           grant_mant;
  logic                      grant_stoch;
  logic [NUM_ROUND_BITS-1:0] rand_in;
  logic [MANT_WIDTH:0]       round_res;

  // Arbitration and operand selection.
  always_comb begin
    can_accept  = (state_q == EMPTY) || out_ready;
    any_valid   = |req_valid;
    grant       = ID_W'(rr_pick(8'(req_valid), 3'(ptr_q), NUM_REQ));
    grant_mant  = {IN_W{1'b0}};
    grant_stoch = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant) begin
        grant_mant  = req_mant[i*IN_W +: IN_W];
        grant_stoch = req_stochastic[i];
      end else begin
        grant_mant  = grant_mant;
        grant_stoch = grant_stoch;
      end
    end
    req_ready = {NUM_REQ{1'b0}};
    if (!rst && can_accept && any_valid) begin
      req_ready[grant] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    accept     = |(req_valid & req_ready);
    grant_next = (grant == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant + ID_W'(1);
  end

  sr_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (NUM_ROUND_BITS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept && grant_stoch),
    .state   (rand_in)
  );

  round #(
    .MANT_WIDTH     (MANT_WIDTH),
    .NUM_ROUND_BITS (NUM_ROUND_BITS)
  ) u_round (
    .mant_in (grant_mant),
    .rand_in (rand_in),
    .mode    (grant_stoch ? RM_STOCH : RM_NEAREST),
    .rounded (round_res)
  );

  // Output register FSM: load on accept, drain when the consumer takes the result.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    out_id_d      = out_id_q;
    out_rounded_d = out_rounded_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d       = FULL;
          ptr_d         = grant_next;
          out_id_d      = grant;
          out_rounded_d = round_res;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (accept) begin
          state_d       = FULL;
          ptr_d         = grant_next;
          out_id_d      = grant;
          out_rounded_d = round_res;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      ptr_q         <= {ID_W{1'b0}};
      out_id_q      <= {ID_W{1'b0}};
      out_rounded_q <= {(MANT_WIDTH+1){1'b0}};
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      out_id_q      <= out_id_d;
      out_rounded_q <= out_rounded_d;
    end
  end

  assign out_valid    = (state_q == FULL);
  assign out_id       = out_id_q;
  assign out_rounded  = out_rounded_q;
  assign out_overflow = out_rounded_q[MANT_WIDTH];

`ifdef ROUND_SCHED_STATS_EN
  logic [31:0] sr_cnt_d, sr_cnt_q;
  logic [31:0] rn_cnt_d, rn_cnt_q;
  logic [31:0] ovf_cnt_d, ovf_cnt_q;

  // Clear wins over any increment in the same cycle.
  always_comb begin
    sr_cnt_d  = sr_cnt_q;
    rn_cnt_d  = rn_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (stat_clr) begin
      sr_cnt_d  = 32'd0;
      rn_cnt_d  = 32'd0;
      ovf_cnt_d = 32'd0;
    end else if (accept) begin
      sr_cnt_d  = grant_stoch ? sr_cnt_q + 32'd1 : sr_cnt_q;
      rn_cnt_d  = grant_stoch ? rn_cnt_q : rn_cnt_q + 32'd1;
      ovf_cnt_d = round_res[MANT_WIDTH] ? ovf_cnt_q + 32'd1 : ovf_cnt_q;
    end else begin
      sr_cnt_d  = sr_cnt_q;
      rn_cnt_d  = rn_cnt_q;
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_cnt_q  <= 32'd0;
      rn_cnt_q  <= 32'd0;
      ovf_cnt_q <= 32'd0;
    end else begin
      sr_cnt_q  <= sr_cnt_d;
      rn_cnt_q  <= rn_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign stat_sr_cnt  = sr_cnt_q;
  assign stat_rn_cnt  = rn_cnt_q;
  assign stat_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_round_sched.sv
// Scoreboard bench for round_sched with MANT_WIDTH=4, NUM_ROUND_BITS=4, NUM_REQ=4.
module tb_round_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_mant;
  logic [3:0]  req_stochastic;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic [4:0]  out_rounded;
  logic        out_overflow;
`ifdef ROUND_SCHED_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_sr_cnt, stat_rn_cnt, stat_ovf_cnt;
  int          m_sr, m_rn, m_ovf;
`endif

  round_sched #(
    .NUM_REQ        (4),
    .MANT_WIDTH     (4),
    .NUM_ROUND_BITS (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mant       (req_mant),
    .req_stochastic (req_stochastic),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_id         (out_id),
    .out_rounded    (out_rounded),
    .out_overflow   (out_overflow)
`ifdef ROUND_SCHED_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_sr_cnt    (stat_sr_cnt),
    .stat_rn_cnt    (stat_rn_cnt),
    .stat_ovf_cnt   (stat_ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [4:0] rnd;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_lfsr;
  int          m_ptr;
  logic        m_full;
  logic        refill;
  logic [3:0]  last_acc;
  logic [6:0]  held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check at negedge, update the model, then release accepted requests.
  task automatic tick();
    logic [3:0] acc;
    logic [3:0] exp_ready;
    logic [8:0] sum;
    logic [7:0] m;
    int         g;
    logic       found;
    exp_t       e;
    @(negedge clk);
    acc = 4'b0000;
    if (rst) begin
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      sb.delete();
      m_lfsr = 16'hACE1;
      m_ptr  = 0;
      m_full = 1'b0;
`ifdef ROUND_SCHED_STATS_EN
      m_sr = 0; m_rn = 0; m_ovf = 0;
`endif
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      found = 1'b0;
      g = 0;
      if (!m_full || out_ready) begin
        for (int i = 0; i < 4; i++) begin
          if (!found && req_valid[(m_ptr + i) % 4]) begin
            found = 1'b1;
            g = (m_ptr + i) % 4;
          end
        end
      end
      exp_ready = found ? (4'b0001 << g) : 4'b0000;
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
      if (m_full && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_id", {30'd0, out_id}, {30'd0, e.id});
        chk("out_rounded", {27'd0, out_rounded}, {27'd0, e.rnd});
        chk("out_overflow", {31'd0, out_overflow}, {31'd0, e.rnd[4]});
      end
      acc = req_valid & req_ready;
      if (found) begin
        m = req_mant[g*8 +: 8];
        if (req_stochastic[g]) begin
          sum = {1'b0, m} + {5'd0, m_lfsr[3:0]};
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end else begin
          sum = {1'b0, m} + 9'h008;
        end
        e.id  = 2'(g);
        e.rnd = sum[8:4];
        sb.push_back(e);
        m_ptr  = (g + 1) % 4;
        m_full = 1'b1;
`ifdef ROUND_SCHED_STATS_EN
        if (!stat_clr) begin
          if (req_stochastic[g]) m_sr++; else m_rn++;
          if (sum[8]) m_ovf++;
        end
`endif
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
`ifdef ROUND_SCHED_STATS_EN
      if (stat_clr) begin
        m_sr = 0; m_rn = 0; m_ovf = 0;
      end
`endif
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    if (refill) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          req_valid[i]          = 1'b1;
          req_mant[i*8 +: 8]    = 8'($urandom_range(0, 255));
          req_stochastic[i]     = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic issue(input int idx, input logic [7:0] mant, input logic st);
    req_valid[idx]        = 1'b1;
    req_mant[idx*8 +: 8]  = mant;
    req_stochastic[idx]   = st;
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 4'b0000;
    req_mant       = 32'd0;
    req_stochastic = 4'b0000;
    out_ready      = 1'b1;
    refill         = 1'b0;
    m_lfsr         = 16'hACE1;
    m_ptr          = 0;
    m_full         = 1'b0;
`ifdef ROUND_SCHED_STATS_EN
    stat_clr = 1'b0;
    m_sr = 0; m_rn = 0; m_ovf = 0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_id", {30'd0, out_id}, 32'd0);
    chk("rst_out_rounded", {27'd0, out_rounded}, 32'd0);
    chk("rst_out_overflow", {31'd0, out_overflow}, 32'd0);
    chk("rst_ptr", {30'd0, dut.ptr_q}, 32'd0);
    chk("rst_lfsr", {16'd0, dut.u_lfsr.state_q}, 32'h0000ACE1);

    // Nearest rounding, no carry.
    issue(0, 8'h18, 1'b0);
    tick();
    chk("t1_id", {30'd0, out_id}, 32'd0);
    chk("t1_rounded", {27'd0, out_rounded}, 32'h02);
    chk("t1_overflow", {31'd0, out_overflow}, 32'd0);
    chk("t1_lfsr", {16'd0, dut.u_lfsr.state_q}, 32'h0000ACE1);
    tick();

    // Nearest rounding with carry-out.
    issue(1, 8'hF8, 1'b0);
    tick();
    chk("t2_rounded", {27'd0, out_rounded}, 32'h10);
    chk("t2_overflow", {31'd0, out_overflow}, 32'd1);
    tick();

    // First stochastic op uses rand_in = 1.
    issue(2, 8'h1F, 1'b1);
    tick();
    chk("t3_rounded", {27'd0, out_rounded}, 32'h02);
    chk("t3_lfsr", {16'd0, dut.u_lfsr.state_q}, 32'h000059C3);
    tick();

    // Continuous load from all requesters after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    refill = 1'b1;
    for (int i = 0; i < 4; i++) issue(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_order", {28'd0, last_acc}, {28'd0, 4'b0001 << (k % 4)});
    end
    for (int k = 0; k < 20; k++) tick();
    refill = 1'b0;
    req_valid = 4'b0000;
    tick();
    tick();

    // Stall with requests pending, then release.
    issue(1, 8'h6C, 1'b0);
    tick();
    out_ready = 1'b0;
    issue(2, 8'h77, 1'b1);
    issue(3, 8'hA5, 1'b0);
    held = {out_id, out_rounded};
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold", {25'd0, out_id, out_rounded}, {25'd0, held});
      chk("stall_ready", {28'd0, req_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", {28'd0, req_ready}, 32'h4);
    tick();

    // Reset while full and stalled discards the pending result.
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_ptr", {30'd0, dut.ptr_q}, 32'd0);
    chk("rst2_lfsr", {16'd0, dut.u_lfsr.state_q}, 32'h0000ACE1);
`ifdef ROUND_SCHED_STATS_EN
    chk("rst2_sr_cnt", stat_sr_cnt, 32'd0);
    chk("rst2_rn_cnt", stat_rn_cnt, 32'd0);
    chk("rst2_ovf_cnt", stat_ovf_cnt, 32'd0);
`endif
    out_ready = 1'b1;
    issue(0, 8'hF9, 1'b1);
    issue(1, 8'h3B, 1'b0);
    for (int k = 0; k < 6; k++) tick();

`ifdef ROUND_SCHED_STATS_EN
    chk("sr_cnt", stat_sr_cnt, 32'(m_sr));
    chk("rn_cnt", stat_rn_cnt, 32'(m_rn));
    chk("ovf_cnt", stat_ovf_cnt, 32'(m_ovf));
    issue(2, 8'hF8, 1'b0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_sr_cnt", stat_sr_cnt, 32'd0);
    chk("clr_rn_cnt", stat_rn_cnt, 32'd0);
    chk("clr_ovf_cnt", stat_ovf_cnt, 32'd0);
    tick();
`endif

    req_valid = 4'b0000;
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
